// File: rtl/bf_pkg.sv
// Shared definitions for the stdout UART transmitter: FSM state encoding and line levels.
// The PARITY state exists only when STDOUT_UART_TX_PARITY_EN is defined.
package bf_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef STDOUT_UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } uart_state_e;

  localparam logic IDLE_LEVEL = 1'b1;
  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;

endpackage

// File: rtl/stdout_uart_tx_if.sv
// Processor-side push port and serial/status outputs of the stdout UART transmitter.
// stdout is taken on every rising edge with stdout_en=1 unless fifo_full was already high (no back-pressure wait).
interface stdout_uart_tx_if;
  import bf_pkg::*;

  logic [7:0]  stdout;
  logic        stdout_en;
  logic        tx;
  logic        fifo_full;
  logic        busy;
  logic        overflow;
  uart_state_e state_dbg;

  modport master (
    output stdout, stdout_en,
    input  tx, fifo_full, busy, overflow, state_dbg
  );

  modport slave (
    input  stdout, stdout_en,
    output tx, fifo_full, busy, overflow, state_dbg
  );
endinterface

// File: rtl/byte_fifo.sv
// Byte FIFO with show-ahead read data; pointers wrap modulo DEPTH (power of two).
// full is registered from the next occupancy count; push when full and pop when empty are ignored.
module byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [7:0]                 wdata,
  output logic [7:0]                 rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          full_q;
  logic          push_ok, pop_ok;

  assign push_ok = push & ~full_q;
  assign pop_ok  = pop & (count_q != '0);

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      full_q  <= (count_d == (AW+1)'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign empty = (count_q == '0);
  assign full  = full_q;
  assign count = count_q;
endmodule

// File: rtl/stdout_uart_tx.sv
// Buffered 8N1 UART transmitter for a processor stdout port, LSB first, idle-high line.
// Define STDOUT_UART_TX_PARITY_EN to insert an even parity bit between DATA and STOP.
module stdout_uart_tx
  import bf_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic             clk,
  input  logic             reset,
  stdout_uart_tx_if.slave  bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  uart_state_e   state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_idx_q;
  logic [2:0]    next_idx;
  logic [7:0]    data_q;
  logic          tx_q;
  logic          overflow_q;
`ifdef STDOUT_UART_TX_PARITY_EN
  logic          parity_q;
`endif

  logic [7:0]    fifo_rdata;
  logic          fifo_full, fifo_empty;
  logic [AW:0]   fifo_count;
  logic          push, pop, bit_end;

  assign push     = bus.stdout_en & ~fifo_full;
  assign bit_end  = (cnt_q == CNT_LAST);
  assign next_idx = bit_idx_q + 3'd1;
  // A new byte is taken either from IDLE or on the last cycle of STOP, so frames chain without a gap.
  assign pop      = ~fifo_empty & ((state_q == IDLE) | ((state_q == STOP) & bit_end));

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (bus.stdout),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      data_q    <= '0;
      tx_q      <= IDLE_LEVEL;
`ifdef STDOUT_UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      if (pop) begin
        data_q   <= fifo_rdata;
`ifdef STDOUT_UART_TX_PARITY_EN
        parity_q <= ^fifo_rdata;
`endif
      end
      if (state_q != IDLE) cnt_q <= bit_end ? '0 : cnt_q + CW'(1);
      case (state_q)
        IDLE: begin
          tx_q <= IDLE_LEVEL;
          if (pop) begin
            state_q <= START;
            tx_q    <= START_BIT;
            cnt_q   <= '0;
          end
        end
        START: begin
          if (bit_end) begin
            state_q   <= DATA;
            bit_idx_q <= '0;
            tx_q      <= data_q[0];
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_idx_q == 3'd7) begin
`ifdef STDOUT_UART_TX_PARITY_EN
              state_q <= PARITY;
              tx_q    <= parity_q;
`else
              state_q <= STOP;
              tx_q    <= STOP_BIT;
`endif
            end else begin
              bit_idx_q <= next_idx;
              tx_q      <= data_q[next_idx];
            end
          end
        end
`ifdef STDOUT_UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            state_q <= STOP;
            tx_q    <= STOP_BIT;
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            if (pop) begin
              state_q <= START;
              tx_q    <= START_BIT;
            end else begin
              state_q <= IDLE;
              tx_q    <= IDLE_LEVEL;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= IDLE_LEVEL;
        end
      endcase
    end
  end

  // Judged on the pre-edge full flag: a pop on the same edge does not make room.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) overflow_q <= 1'b0;
    else if (bus.stdout_en & fifo_full) overflow_q <= 1'b1;
  end

  assign bus.tx        = tx_q;
  assign bus.fifo_full = fifo_full;
  assign bus.busy      = (state_q != IDLE) | (fifo_count != '0);
  assign bus.overflow  = overflow_q;
  assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_stdout_uart_tx.sv
// Directed bench for stdout_uart_tx at CLKS_PER_BIT=4, FIFO_DEPTH=8; frame checks sample every cycle.
// Honours STDOUT_UART_TX_PARITY_EN when the bundle is built with it.
module tb_stdout_uart_tx;
  import bf_pkg::*;

  localparam int CPB = 4;
`ifdef STDOUT_UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  typedef struct {
    logic [7:0] data;
    logic [9:0] exp_line;  // line level per bit time, bit 0 = start ... bit 9 = stop
    logic       exp_par;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  vec_t vec [7];

  stdout_uart_tx_if bus ();

  stdout_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at the negedge of the first start-bit cycle; returns at the negedge after the stop bit.
  task automatic check_frame(input int idx, input string tag);
    logic [CPB-1:0] s;
    logic           e;
    logic           busy_all;
    busy_all = 1'b1;
    for (int b = 0; b < NBITS; b++) begin
      if (b < 9) e = vec[idx].exp_line[b];
      else if (b == NBITS - 1) e = vec[idx].exp_line[9];
      else e = vec[idx].exp_par;
      for (int c = 0; c < CPB; c++) begin
        s[c] = bus.tx;
        busy_all &= bus.busy;
        @(negedge clk);
      end
      check($sformatf("%s_bit%0d", tag, b), 32'(s), 32'({CPB{e}}));
    end
    check($sformatf("%s_busy", tag), 32'(busy_all), 32'd1);
  endtask

  task automatic wait_start(input int budget, input string tag);
    int n;
    n = 0;
    while (bus.tx !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("%s_start_seen", tag), 32'(bus.tx === 1'b0), 32'd1);
  endtask

  task automatic check_idle(input string tag);
    check($sformatf("%s_idle_busy", tag), 32'(bus.busy), 32'd0);
    check($sformatf("%s_idle_tx", tag), 32'(bus.tx), 32'd1);
    check($sformatf("%s_idle_state", tag), 32'(bus.state_dbg), 32'(IDLE));
  endtask

  task automatic send_single(input int idx, input string tag);
    @(negedge clk);
    bus.stdout    = vec[idx].data;
    bus.stdout_en = 1'b1;
    @(negedge clk);
    bus.stdout_en = 1'b0;
    check($sformatf("%s_tx_before", tag), 32'(bus.tx), 32'd1);
    check($sformatf("%s_busy_queued", tag), 32'(bus.busy), 32'd1);
    @(negedge clk);
    check_frame(idx, tag);
    check_idle(tag);
  endtask

  task automatic quiet_line(input int cycles, input string tag);
    logic tx_hi, busy_lo;
    tx_hi = 1'b1;
    busy_lo = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      tx_hi &= bus.tx;
      busy_lo &= ~bus.busy;
      @(negedge clk);
    end
    check($sformatf("%s_quiet_tx", tag), 32'(tx_hi), 32'd1);
    check($sformatf("%s_quiet_busy", tag), 32'(busy_lo), 32'd1);
  endtask

  initial begin
    logic full_seen;
    vec[0] = '{8'h48, 10'b1010010000, 1'b0};
    vec[1] = '{8'h07, 10'b1000001110, 1'b1};
    vec[2] = '{8'h00, 10'b1000000000, 1'b0};
    vec[3] = '{8'hFF, 10'b1111111110, 1'b0};
    vec[4] = '{8'h41, 10'b1010000010, 1'b0};
    vec[5] = '{8'h42, 10'b1010000100, 1'b0};
    vec[6] = '{8'h80, 10'b1100000000, 1'b1};
    bus.stdout    = 8'h00;
    bus.stdout_en = 1'b0;

    // Reset values while reset is held.
    repeat (2) @(negedge clk);
    check("rst_tx", 32'(bus.tx), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_full", 32'(bus.fifo_full), 32'd0);
    check("rst_overflow", 32'(bus.overflow), 32'd0);
    check("rst_state", 32'(bus.state_dbg), 32'(IDLE));
    reset = 1'b0;
    @(negedge clk);

    // Single frames from IDLE, one per table entry.
    for (int i = 0; i < 7; i++) send_single(i, $sformatf("v%0d", i));

    // Two pushes on consecutive cycles: second frame follows the first stop bit directly.
    @(negedge clk);
    bus.stdout = vec[4].data;
    bus.stdout_en = 1'b1;
    @(negedge clk);
    bus.stdout = vec[5].data;
    @(negedge clk);
    bus.stdout_en = 1'b0;
    check_frame(4, "b2b_a");
    check_frame(5, "b2b_b");
    check_idle("b2b");

    // Ten pushes on consecutive cycles: nine frames, tenth byte dropped.
    full_seen = 1'b0;
    @(negedge clk);
    check("ovf_pre", 32'(bus.overflow), 32'd0);
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          bus.stdout = vec[i % 7].data;
          bus.stdout_en = 1'b1;
          @(negedge clk);
          full_seen |= bus.fifo_full;
        end
        bus.stdout_en = 1'b0;
      end
      begin
        wait_start(20, "ovf_f0");
        for (int f = 0; f < 9; f++) check_frame(f % 7, $sformatf("ovf_f%0d", f));
      end
    join
    check("ovf_full_seen", 32'(full_seen), 32'd1);
    check("ovf_flag", 32'(bus.overflow), 32'd1);
    check_idle("ovf");
    quiet_line(60, "ovf_no_tenth");
    check("ovf_sticky", 32'(bus.overflow), 32'd1);

    // Reset during DATA bit 3 with three bytes still queued.
    @(negedge clk);
    bus.stdout_en = 1'b1;
    bus.stdout = vec[2].data;
    @(negedge clk);
    bus.stdout = vec[0].data;
    @(negedge clk);
    bus.stdout = vec[1].data;
    @(negedge clk);
    bus.stdout = vec[3].data;
    @(negedge clk);
    bus.stdout_en = 1'b0;
    repeat (15) @(negedge clk);
    check("mid_state", 32'(bus.state_dbg), 32'(DATA));
    check("mid_tx_bit3", 32'(bus.tx), 32'd0);
    check("mid_full", 32'(bus.fifo_full), 32'd0);
    reset = 1'b1;
    #1;
    check("mid_rst_tx", 32'(bus.tx), 32'd1);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_overflow", 32'(bus.overflow), 32'd0);
    check("mid_rst_state", 32'(bus.state_dbg), 32'(IDLE));
    @(negedge clk);
    reset = 1'b0;
    quiet_line(60, "post_rst");

    // Transmission resumes normally after reset.
    send_single(4, "recover");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
